// File: rtl/data_cache_pkg.sv
// Shared types and funct3 size encodings for the direct-mapped write-through data cache.
package data_cache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } cacheState_t;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

endpackage

// File: rtl/data_cache_align.sv
// Combinational load extraction (sign/zero extension) and store lane placement.
// Misaligned halfword/word offsets are truncated to their natural alignment.
module data_cache_align
  import data_cache_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            sizeCtr,
  input  logic [1:0]            byteOff,
  input  logic [DATA_WIDTH-1:0] rawWord,
  input  logic [DATA_WIDTH-1:0] storeData,
  output logic [DATA_WIDTH-1:0] loadData,
  output logic [DATA_WIDTH-1:0] storeWord,
  output logic [3:0]            byteEn
);

  logic [7:0]  byteVal;
  logic [15:0] halfVal;

  assign byteVal = rawWord[{byteOff, 3'b000} +: 8];
  assign halfVal = rawWord[{byteOff[1], 4'b0000} +: 16];

  always_comb begin
    // NOTE: every output gets a default before the case, so no path can infer a latch.
    loadData = rawWord;
    case (sizeCtr)
      LB:      loadData = {{(DATA_WIDTH-8){byteVal[7]}}, byteVal};
      LH:      loadData = {{(DATA_WIDTH-16){halfVal[15]}}, halfVal};
      LBU:     loadData = {{(DATA_WIDTH-8){1'b0}}, byteVal};
      LHU:     loadData = {{(DATA_WIDTH-16){1'b0}}, halfVal};
      default: loadData = rawWord;
    endcase
  end

  always_comb begin
    storeWord = storeData;
    byteEn    = 4'b1111;
    case (sizeCtr)
      SB: begin
        storeWord = {4{storeData[7:0]}};
        byteEn    = 4'b0001 << byteOff;
      end
      SH: begin
        storeWord = {2{storeData[15:0]}};
        byteEn    = byteOff[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        storeWord = storeData;
        byteEn    = 4'b1111;
      end
    endcase
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, one-word-per-line, write-through / no-write-allocate data cache.
// Read hits return in the same cycle; misses and all stores go to backing memory.
module data_cache
  import data_cache_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int SETS       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  memRead,
  input  logic                  memWrite,
  input  logic [2:0]            sizeCtr,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] writeData,
  output logic [DATA_WIDTH-1:0] readData,
  output logic                  stall,
  output logic                  bmReq,
  output logic                  bmWe,
  output logic [ADDR_WIDTH-1:0] bmAddr,
  output logic [DATA_WIDTH-1:0] bmWData,
  output logic [3:0]            bmByteEn,
  input  logic                  bmAck,
  input  logic [DATA_WIDTH-1:0] bmRData
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_WIDTH - 2 - IDX_W;

  cacheState_t state, nextState;

  logic [SETS-1:0]       validArr;
  logic [TAG_W-1:0]      tagArr  [SETS];
  logic [DATA_WIDTH-1:0] dataArr [SETS];

  logic [IDX_W-1:0]      index;
  logic [TAG_W-1:0]      reqTag;
  logic                  hit;
  logic                  isWrite;
  logic                  isRead;
  logic [DATA_WIDTH-1:0] lineWord;
  logic [DATA_WIDTH-1:0] loadWord;

  assign index   = addr[2+IDX_W-1:2];
  assign reqTag  = addr[ADDR_WIDTH-1:2+IDX_W];
  assign hit     = validArr[index] && (tagArr[index] == reqTag);
  assign isWrite = memWrite;
  assign isRead  = memRead && !memWrite;
  assign bmAddr  = {addr[ADDR_WIDTH-1:2], 2'b00};

  // During a fill the returning word is forwarded straight through extraction.
  assign lineWord = (state == FILL) ? bmRData : dataArr[index];

  data_cache_align #(.DATA_WIDTH(DATA_WIDTH)) alignUnit (
    .sizeCtr   (sizeCtr),
    .byteOff   (addr[1:0]),
    .rawWord   (lineWord),
    .storeData (writeData),
    .loadData  (loadWord),
    .storeWord (bmWData),
    .byteEn    (bmByteEn)
  );

  always_comb begin
    nextState = state;
    stall     = 1'b0;
    bmReq     = 1'b0;
    bmWe      = 1'b0;
    readData  = '0;
    case (state)
      IDLE: begin
        if (isWrite) begin
          stall     = 1'b1;
          nextState = WRITE;
        end else if (isRead) begin
          if (hit) begin
            readData = loadWord;
          end else begin
            stall     = 1'b1;
            nextState = FILL;
          end
        end
      end
      FILL: begin
        bmReq = 1'b1;
        stall = !bmAck;
        if (bmAck) begin
          readData  = loadWord;
          nextState = IDLE;
        end
      end
      WRITE: begin
        bmReq = 1'b1;
        bmWe  = 1'b1;
        stall = !bmAck;
        if (bmAck) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
    // Reset overrides everything and abandons any outstanding transaction.
    if (rst) begin
      nextState = IDLE;
      stall     = 1'b0;
      bmReq     = 1'b0;
      bmWe      = 1'b0;
      readData  = '0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values together.
    if (rst) begin
      state    <= IDLE;
      validArr <= '0;
    end else begin
      state <= nextState;
      if (state == FILL && bmAck) validArr[index] <= 1'b1;
    end
  end

  // NOTE: tag and data arrays are deliberately not reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (!rst && state == FILL && bmAck) begin
      tagArr[index]  <= reqTag;
      dataArr[index] <= bmRData;
    end
    if (!rst && state == WRITE && bmAck && hit) begin
      for (int b = 0; b < 4; b++) begin
        if (bmByteEn[b]) dataArr[index][8*b +: 8] <= bmWData[8*b +: 8];
      end
    end
  end

endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 Parameter DATA_WIDTH, default 32, data word width.
REQ-002 Parameter ADDR_WIDTH, default 32, byte address width.
REQ-003 Parameter SETS, default 16, number of direct-mapped one-word lines; power of two.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 memRead  in  1  load request from memory stage.
REQ-008 memWrite  in  1  store request from memory stage.
REQ-009 sizeCtr  in  3  funct3 of the access.
REQ-010 addr  in  ADDR_WIDTH  byte address (ALU result).
REQ-011 writeData  in  DATA_WIDTH  store data, unshifted.
REQ-012 readData  out  DATA_WIDTH  load result, aligned and extended.
REQ-013 stall  out  1  pipeline hold; the request inputs are held stable while high.
REQ-014 bmReq  out  1  backing-memory request.
REQ-015 bmWe  out  1  backing-memory write enable.
REQ-016 bmAddr  out  ADDR_WIDTH  word-aligned address, with bits [1:0] = 0.
REQ-017 bmWData  out  DATA_WIDTH  lane-shifted store data.
REQ-018 bmByteEn  out  4  byte-lane enables.
REQ-019 bmAck  in  1  one-cycle completion pulse.
REQ-020 bmRData  in  DATA_WIDTH  fill data, valid when bmAck is high.

Function
REQ-021 Address fields SHALL be: index = addr[2+log2(SETS)-1:2]; tag = the remaining upper bits.
REQ-022 A hit SHALL mean the indexed line is valid and its tag equals the request tag.
REQ-023 The FSM SHALL have three states: IDLE, FILL and WRITE.
REQ-024 In IDLE, a read hit SHALL drive readData combinationally with stall = 0; the latency is 0 cycles.
REQ-025 In IDLE, a read miss SHALL assert stall in the same cycle and move to FILL.
REQ-026 In IDLE, any write SHALL assert stall and move to WRITE; the cache is write-through and no-write-allocate.
REQ-027 If memRead and memWrite are both high, the access SHALL be treated as a write.
REQ-028 In FILL, the block SHALL drive bmReq = 1, bmWe = 0 and bmAddr = the word address, and keep stall = ~bmAck.
REQ-029 On bmAck in FILL, the block SHALL write the line (valid, tag, bmRData), forward bmRData through load extraction to readData, and return to IDLE.
REQ-030 In WRITE, the block SHALL drive bmReq = 1, bmWe = 1, bmWData and bmByteEn, and keep stall = ~bmAck.
REQ-031 On bmAck in WRITE, the block SHALL update the enabled bytes of the line only if it is a hit, then return to IDLE.
REQ-032 bmReq, bmAddr, bmWData and bmByteEn SHALL stay constant from assertion until the bmAck cycle.
REQ-033 bmAck received in IDLE SHALL be ignored.
REQ-034 Load sizeCtr decoding SHALL be:
  - 000 LB: sign-extended byte addr[1:0];
  - 001 LH: sign-extended half addr[1];
  - 010 LW;
  - 100 LBU;
  - 101 LHU;
  - other codes: LW.
REQ-035 Store sizeCtr decoding SHALL be:
  - 000 SB: byteEn = 1 << addr[1:0], data replicated per lane;
  - 001 SH: byteEn = 0011 or 1100 by addr[1];
  - other codes: SW, byteEn = 1111.
REQ-036 Misaligned halfword/word addresses SHALL be truncated to alignment (addr[0], addr[1:0] ignored); no exception is raised.
REQ-037 readData SHALL be 0 when no read completes in the cycle.
REQ-038 With no request in IDLE, stall and bmReq SHALL be 0.

Reset
REQ-039 When rst is sampled high, the block SHALL clear all valid bits, set state to IDLE and abandon any in-flight transaction.
REQ-040 While rst is high, stall, bmReq, bmWe and readData SHALL be 0 (combinationally gated).
REQ-041 A bmAck arriving in the cycle after a reset SHALL be ignored.

Structure
REQ-042 Package data_cache_pkg SHALL hold the state enum and the funct3 size constants (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-043 Load extraction and store lane-shifting SHALL be in sub-module data_cache_align, which is purely combinational.
REQ-044 Tag, valid and data arrays SHALL be flop arrays of SETS entries.

Verification
REQ-045 After reset, LW at 0x100 with bmAck on the 3rd FILL cycle returning 0xDEADBEEF -> stall is high for 3 cycles, readData = 0xDEADBEEF in the ack cycle, and a repeat LW at 0x100 hits with stall = 0.
REQ-046 LB at 0x103 on a line holding 0x80FF1234 -> 0xFFFFFF80; LBU at 0x103 -> 0x00000080; LHU at 0x102 -> 0x000080FF.
REQ-047 SB 0xAB at 0x101 (hit) -> bmByteEn = 0010, bmWData = 0xABABABAB, bmAddr = 0x100, and the line reads 0x80FFAB34 afterwards.
REQ-048 SW at 0x200 (miss) -> one backing-memory write with bmByteEn = 1111, the line is not allocated, and a following LW at 0x200 misses.
REQ-049 rst asserted during FILL before bmAck, then a late bmAck -> state is IDLE, bmReq = 0, the ack is ignored and all lines are invalid.
REQ-050 Index alias: fill 0x100 then LW at 0x140 (SETS = 16, same index) -> miss, line replaced, and LW at 0x100 misses again.
